ldl_round_age: RTL and testbench

- Anti-starvation aging stage placed directly upstream of the priority round-robin arbiter (LDL_round_pri).
- Takes each requester's base class-of-service (cos), counts how long each active request has waited without a grant, and raises its effective cos by one level per AGE_THRESH waiting cycles, up to the top cos.
- Its req_o/cos_o feed the arbiter's req/cos inputs. The arbiter's ack/hot outputs come back here as grant feedback.

---
 rtl/ldl_round_pkg.sv | 34 +++
 rtl/ldl_round_age_lane.sv | 107 ++++++++++
 rtl/ldl_round_age.sv | 54 +++++
 tb/tb_ldl_round_age.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ldl_round_pkg.sv
// ldl_round_pkg
//   Definitions shared by the round-robin aging stage (ldl_round_age) and the
//   priority arbiter it feeds (ldl_round_pri).
//   - COS_WIDTH / COS_MAX : class-of-service field width and top level
//   - cos_t               : one class-of-service value
//   - lane_mode_t         : per-requester aging event for one clock edge
//   - sat_add_cos()       : base + boost, clamped at COS_MAX (never wraps)
package ldl_round_pkg;

  localparam int COS_WIDTH = 2;

  typedef logic [COS_WIDTH-1:0] cos_t;

  localparam cos_t COS_MAX = {COS_WIDTH{1'b1}};

  typedef enum logic [1:0] {
    LANE_IDLE    = 2'd0,  // no request: aging forfeited
    LANE_GRANTED = 2'd1,  // request served this cycle: aging cleared
    LANE_FROZEN  = 2'd2,  // aging disabled: hold everything
    LANE_WAIT    = 2'd3   // request waiting: advance timer / boost
  } lane_mode_t;

  // Sum is formed one bit wider so the carry is visible before clamping.
  function automatic cos_t sat_add_cos(input cos_t base, input cos_t boost);
    logic [COS_WIDTH:0] sum;
    sum = {1'b0, base} + {1'b0, boost};
    if (sum > {1'b0, COS_MAX}) begin
      sat_add_cos = COS_MAX;
    end else begin
      sat_add_cos = sum[COS_WIDTH-1:0];
    end
  endfunction

endpackage

// File: rtl/ldl_round_age_lane.sv
// ldl_round_age_lane
//   Aging state for a single requester: a wait timer that wraps every
//   AGE_THRESH waiting cycles and a saturating boost level bumped on each wrap.
//   Ports:
//     clk, rst_n   : clock, asynchronous active-low reset
//     aging_en     : 0 freezes timer and boost
//     req          : this requester's raw request
//     gnt          : this requester was granted this cycle (ack & hot already applied)
//     base_cos     : base class-of-service
//     cos_o        : effective class-of-service (combinational)
//     aged         : boost is non-zero
module ldl_round_age_lane
  import ldl_round_pkg::*;
#(
  parameter int AGE_THRESH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic aging_en,
  input  logic req,
  input  logic gnt,
  input  cos_t base_cos,
  output cos_t cos_o,
  output logic aged
);

  localparam int TMR_W = (AGE_THRESH > 1) ? $clog2(AGE_THRESH) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(AGE_THRESH - 1);
  localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);
  localparam cos_t COS_ONE = cos_t'(1);

  logic [TMR_W-1:0] tmr;
  logic [TMR_W-1:0] tmr_nxt;
  cos_t             boost;
  cos_t             boost_nxt;
  lane_mode_t       mode;

  // Timer and boost registers; reset discards all aging history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmr   <= '0;
      boost <= '0;
    end else begin
      tmr   <= tmr_nxt;
      boost <= boost_nxt;
    end
  end

  // Classify this edge; grant outranks the enable so a served request always clears.
  always_comb begin
    mode = LANE_IDLE;
    if (!req) begin
      mode = LANE_IDLE;
    end else if (gnt) begin
      mode = LANE_GRANTED;
    end else if (!aging_en) begin
      mode = LANE_FROZEN;
    end else begin
      mode = LANE_WAIT;
    end
  end

  // Next timer/boost; boost saturates while the timer keeps wrapping.
  always_comb begin
    tmr_nxt   = tmr;
    boost_nxt = boost;
    case (mode)
      LANE_IDLE, LANE_GRANTED: begin
        tmr_nxt   = '0;
        boost_nxt = '0;
      end
      LANE_FROZEN: begin
        tmr_nxt   = tmr;
        boost_nxt = boost;
      end
      LANE_WAIT: begin
        if (tmr != TMR_LAST) begin
          tmr_nxt   = tmr + TMR_ONE;
          boost_nxt = boost;
        end else begin
          tmr_nxt = '0;
          if (boost != COS_MAX) begin
            boost_nxt = boost + COS_ONE;
          end else begin
            boost_nxt = boost;
          end
        end
      end
      default: begin
        tmr_nxt   = '0;
        boost_nxt = '0;
      end
    endcase
  end

  // Effective cos: an idle lane shows its base cos even if a stale boost is still registered.
  always_comb begin
    if (req) begin
      cos_o = sat_add_cos(base_cos, boost);
    end else begin
      cos_o = base_cos;
    end
  end

  assign aged = (boost != '0);

endmodule

// File: rtl/ldl_round_age.sv
// ldl_round_age
//   Anti-starvation aging stage in front of the priority round-robin arbiter.
//   Each waiting request has its class-of-service raised one level every
//   AGE_THRESH cycles without a grant, up to COS_MAX.
//   Ports:
//     clk, rst_n : clock, asynchronous active-low reset
//     aging_en   : 1 = aging active, 0 = freeze timers and boosts
//     req        : raw requests, one bit per requester
//     base_cos   : base cos, COS_WIDTH bits per requester (requester i at [i*COS_WIDTH +: COS_WIDTH])
//     ack, hot   : arbiter grant valid / one-hot grant (hot ignored without ack)
//     req_o      : req passed straight through
//     cos_o      : effective cos per requester, same packing as base_cos
//     aged       : per-requester "boost is non-zero"
module ldl_round_age
  import ldl_round_pkg::*;
#(
  parameter int BIN_WIDTH  = 3,
  parameter int AGE_THRESH = 4
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 aging_en,
  input  logic [(1<<BIN_WIDTH)-1:0]            req,
  input  logic [(1<<BIN_WIDTH)*COS_WIDTH-1:0]  base_cos,
  input  logic                                 ack,
  input  logic [(1<<BIN_WIDTH)-1:0]            hot,
  output logic [(1<<BIN_WIDTH)-1:0]            req_o,
  output logic [(1<<BIN_WIDTH)*COS_WIDTH-1:0]  cos_o,
  output logic [(1<<BIN_WIDTH)-1:0]            aged
);

  localparam int REQ_WIDTH = 1 << BIN_WIDTH;

  // A malformed multi-bit hot with ack simply clears every flagged lane.
  logic [REQ_WIDTH-1:0] gnt;
  assign gnt   = hot & {REQ_WIDTH{ack}};
  assign req_o = req;

  for (genvar i = 0; i < REQ_WIDTH; i++) begin : g_lane
    ldl_round_age_lane #(
      .AGE_THRESH (AGE_THRESH)
    ) u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .aging_en (aging_en),
      .req      (req[i]),
      .gnt      (gnt[i]),
      .base_cos (base_cos[i*COS_WIDTH +: COS_WIDTH]),
      .cos_o    (cos_o[i*COS_WIDTH +: COS_WIDTH]),
      .aged     (aged[i])
    );
  end

endmodule

// File: tb/tb_ldl_round_age.sv
// tb_ldl_round_age
//   Directed scenarios for reset, the aging ladder, grant clear, saturation,
//   drop/freeze and ack gating, then randomized traffic; all outputs are
//   compared with a per-requester wait/boost model kept in integers.
module tb_ldl_round_age;

  localparam int N   = 8;
  localparam int CW  = 2;
  localparam int AT  = 4;
  localparam int CMX = 3;

  logic            clk;
  logic            rst_n;
  logic            aging_en;
  logic [N-1:0]    req;
  logic [N*CW-1:0] base_cos;
  logic            ack;
  logic [N-1:0]    hot;
  logic [N-1:0]    req_o;
  logic [N*CW-1:0] cos_o;
  logic [N-1:0]    aged;

  int n_checks = 0;
  int n_bad    = 0;

  // reference model: cycles waited since last boost, and boost level
  int mw [N];
  int mb [N];

  ldl_round_age #(
    .BIN_WIDTH  (3),
    .AGE_THRESH (AT)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .aging_en (aging_en),
    .req      (req),
    .base_cos (base_cos),
    .ack      (ack),
    .hot      (hot),
    .req_o    (req_o),
    .cos_o    (cos_o),
    .aged     (aged)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int lane_cos(input int i);
    logic [N*CW-1:0] v;
    v = cos_o;
    return int'(v[i*CW +: CW]);
  endfunction

  function automatic int base_of(input int i);
    logic [N*CW-1:0] v;
    v = base_cos;
    return int'(v[i*CW +: CW]);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < N; i++) begin
      mw[i] = 0;
      mb[i] = 0;
    end
  endtask

  task automatic compare_all(input string tag);
    logic [N*CW-1:0] ec;
    logic [N-1:0]    ea;
    int              s;
    for (int i = 0; i < N; i++) begin
      s = base_of(i);
      if (req[i]) begin
        s = s + mb[i];
        if (s > CMX) s = CMX;
      end
      ec[i*CW +: CW] = CW'(s);
      ea[i]          = (mb[i] != 0);
    end
    check({tag, ".req_o"}, 32'(req_o), 32'(req));
    check({tag, ".cos_o"}, 32'(cos_o), 32'(ec));
    check({tag, ".aged"},  32'(aged),  32'(ea));
  endtask

  // one rising edge: advance the model from the inputs held across it, then compare
  task automatic tick(input string tag);
    int nw [N];
    int nb [N];
    for (int i = 0; i < N; i++) begin
      nw[i] = mw[i];
      nb[i] = mb[i];
      if (!rst_n || !req[i] || (ack && hot[i])) begin
        nw[i] = 0;
        nb[i] = 0;
      end else if (aging_en) begin
        nw[i] = mw[i] + 1;
        if (nw[i] == AT) begin
          nw[i] = 0;
          if (mb[i] < CMX) nb[i] = mb[i] + 1;
        end
      end
    end
    @(posedge clk);
    for (int i = 0; i < N; i++) begin
      mw[i] = nw[i];
      mb[i] = nb[i];
    end
    #1;
    compare_all(tag);
    @(negedge clk);
  endtask

  // reset pulse spanning one rising edge; outputs checked while reset is low
  task automatic apply_reset(input string tag);
    rst_n = 1'b0;
    #1;
    model_clear();
    compare_all(tag);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic idle_inputs();
    req      = '0;
    base_cos = '0;
    ack      = 1'b0;
    hot      = '0;
    aging_en = 1'b1;
  endtask

  initial begin
    rst_n    = 1'b0;
    idle_inputs();
    model_clear();
    req      = 8'hA5;
    base_cos = 16'h1B6C;
    #1;
    compare_all("reset");
    check("reset.cos_eq_base", 32'(cos_o), 32'h0000_1B6C);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle_inputs();

    // 1. reset mid-count
    req = 8'h08;
    for (int e = 1; e <= 6; e++) tick("t1.age");
    check("t1.cos3_after6", 32'(lane_cos(3)), 32'd1);
    rst_n = 1'b0;
    #1;
    model_clear();
    check("t1.cos3_in_reset", 32'(lane_cos(3)), 32'd0);
    check("t1.aged_in_reset", 32'(aged), 32'd0);
    tick("t1.rst_edge");
    rst_n = 1'b1;
    for (int e = 1; e <= 3; e++) tick("t1.rel");
    check("t1.cos3_after3", 32'(lane_cos(3)), 32'd0);
    tick("t1.rel4");
    check("t1.cos3_after4", 32'(lane_cos(3)), 32'd1);

    // 2. aging ladder
    idle_inputs();
    apply_reset("t2.rst");
    req = 8'h04;
    for (int e = 1; e <= 20; e++) begin
      tick("t2.ladder");
      check("t2.cos2", 32'(lane_cos(2)), 32'((e / AT > CMX) ? CMX : e / AT));
      check("t2.aged", 32'(aged), (e >= AT) ? 32'h04 : 32'h00);
    end

    // 3. grant clears
    idle_inputs();
    apply_reset("t3.rst");
    req = 8'h04;
    for (int e = 1; e <= 8; e++) tick("t3.age");
    check("t3.cos2_pre", 32'(lane_cos(2)), 32'd2);
    ack = 1'b1;
    hot = 8'h04;
    tick("t3.grant");
    ack = 1'b0;
    hot = '0;
    check("t3.cos2_clr", 32'(lane_cos(2)), 32'd0);
    check("t3.aged_clr", 32'(aged), 32'd0);
    for (int e = 1; e <= 3; e++) tick("t3.re");
    check("t3.cos2_re3", 32'(lane_cos(2)), 32'd0);
    tick("t3.re4");
    check("t3.cos2_re4", 32'(lane_cos(2)), 32'd1);

    // 4. saturation
    idle_inputs();
    apply_reset("t4.rst");
    req      = 8'h02;
    base_cos = 16'h0008;
    for (int e = 1; e <= 4; e++) tick("t4.sat");
    check("t4.cos1_e4", 32'(lane_cos(1)), 32'd3);
    for (int e = 1; e <= 4; e++) tick("t4.sat");
    check("t4.cos1_e8", 32'(lane_cos(1)), 32'd3);
    check("t4.aged_e8", 32'(aged), 32'h02);

    // 5. drop then freeze
    idle_inputs();
    apply_reset("t5.rst");
    req = 8'h20;
    for (int e = 1; e <= 6; e++) tick("t5.age");
    check("t5.cos5_e6", 32'(lane_cos(5)), 32'd1);
    req = 8'h00;
    tick("t5.drop");
    check("t5.aged_drop", 32'(aged), 32'd0);
    req = 8'h20;
    for (int e = 1; e <= 3; e++) tick("t5.re");
    check("t5.cos5_re3", 32'(lane_cos(5)), 32'd0);
    tick("t5.re4");
    check("t5.cos5_re4", 32'(lane_cos(5)), 32'd1);
    tick("t5.pre1");
    tick("t5.pre2");
    aging_en = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      tick("t5.frz");
      check("t5.cos5_frz", 32'(lane_cos(5)), 32'd1);
    end
    aging_en = 1'b1;
    tick("t5.thaw1");
    check("t5.cos5_thaw1", 32'(lane_cos(5)), 32'd1);
    tick("t5.thaw2");
    check("t5.cos5_thaw2", 32'(lane_cos(5)), 32'd2);

    // 6. ack gating
    idle_inputs();
    apply_reset("t6.rst");
    req = 8'h11;
    for (int e = 1; e <= 4; e++) tick("t6.age");
    hot = 8'h10;
    tick("t6.noack");
    check("t6.cos4_noack", 32'(lane_cos(4)), 32'd1);
    check("t6.cos0_noack", 32'(lane_cos(0)), 32'd1);
    ack = 1'b1;
    tick("t6.ack");
    ack = 1'b0;
    hot = '0;
    check("t6.cos4_ack", 32'(lane_cos(4)), 32'd0);
    check("t6.cos0_ack", 32'(lane_cos(0)), 32'd1);
    check("t6.aged_ack", 32'(aged), 32'h01);

    // randomized traffic
    idle_inputs();
    apply_reset("rnd.rst");
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) req[i] = ($urandom_range(9) < 8);
      base_cos = 16'($urandom);
      aging_en = ($urandom_range(9) != 0);
      ack      = ($urandom_range(4) == 0);
      if ($urandom_range(3) != 0) hot = 8'(1 << $urandom_range(N - 1));
      else                        hot = 8'($urandom);
      #1;
      compare_all("rnd.comb");
      if ($urandom_range(149) == 0) begin
        rst_n = 1'b0;
        #1;
        model_clear();
        compare_all("rnd.async_rst");
        #1;
        rst_n = 1'b1;
      end
      tick("rnd.edge");
    end

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
